mem_bus_unit: RTL and testbench
===============================

Name: mem_bus_unit

Overview:
- Parametrised successor of the pipeline memory-access stage: performs loads, stores and LL/SC as multi-cycle bus transactions instead of single-cycle combinational accesses.
- Sits between EX/MEM and the data-side Wishbone-style bus.
- Adds stall generation, bus wait states, an ack timeout, alignment checking with exception reporting, an internal LL bit, and configurable data width (32 or 64).

Parameters:
DATA_W, 32, data bus width; 32 or 64 only
ADDR_W, 32, address width
TIMEOUT, 255, bus cycles without ack/err before abort; range 1..65535

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
req_valid_i  in  1  access request from EX/MEM; held stable while stall_o=1
op_store_i  in  1  1=store, 0=load
op_size_i  in  2  0=byte, 1=half, 2=word, 3=dword (DATA_W=64 only)
op_unsigned_i  in  1  zero-extend load result
op_llsc_i  in  1  with load=LL, with store=SC
addr_i  in  ADDR_W  byte address
wdata_i  in  DATA_W  store data, right-aligned
flush_i  in  1  pipeline flush / exception return; clears LL bit
stall_o  out  1  hold pipeline
resp_valid_o  out  1  one-cycle result pulse
rdata_o  out  DATA_W  load data, or SC status
exc_o  out  2  0 none, 1 misaligned/illegal, 2 bus error, 3 timeout
bus_cyc_o  out  1  bus cycle active
bus_stb_o  out  1  strobe; equals bus_cyc_o
bus_we_o  out  1  write enable
bus_adr_o  out  ADDR_W  address, aligned to DATA_W/8
bus_sel_o  out  DATA_W/8  byte lane selects
bus_dat_o  out  DATA_W  write data
bus_dat_i  in  DATA_W  read data
bus_ack_i  in  1  transfer complete
bus_err_i  in  1  transfer error

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, LL bit 0, timeout counter 0. Reset mid-transaction drops bus_cyc_o immediately.
- Byte order is big-endian. The byte at offset k within the bus word maps to lane bus_sel_o[NB-1-k], with NB=DATA_W/8.
- FSM states: IDLE, BUS, RESP.
- IDLE: when req_valid_i=1, the request is accepted and stall_o=1 combinationally in that cycle. Decode outcome:
  - Misaligned (addr not a multiple of the size), size 3 with DATA_W=32, or LL/SC with size other than word/dword: go to RESP with exc=1, no bus cycle.
  - SC with LL bit 0: go to RESP with rdata=0, exc=0, no bus cycle.
  - Otherwise: go to BUS. Register bus_adr_o (low log2(NB) bits zeroed), bus_sel_o, bus_we_o and bus_dat_o. Store data replicates the low 2^size bytes of wdata_i across all lanes.
- BUS: bus_cyc_o=bus_stb_o=1 and stall_o=1; the timeout counter increments each cycle.
  - bus_ack_i=1: deassert cyc next edge and go to RESP. Loads capture the selected bytes, sign- or zero-extended to DATA_W, into rdata_o. LL sets the LL bit. SC clears the LL bit and sets rdata=1.
  - bus_err_i=1: go to RESP with exc=2 and rdata=0. err takes priority over a simultaneous ack.
  - Counter reaches TIMEOUT with no ack/err: abort cyc and go to RESP with exc=3.
- RESP: resp_valid_o=1 for exactly one cycle and stall_o=0; the pipeline advances at this edge. The request is not re-accepted in this cycle. Next state is IDLE.
- rdata_o and exc_o hold their values until the next RESP. In any non-RESP cycle resp_valid_o=0.
- Latency: minimum 2 cycles (accept + RESP) for no-bus outcomes. Bus outcomes take 2 + number of BUS cycles, with at least 1 BUS cycle.
- flush_i: synchronous; clears the LL bit. flush_i and an LL ack in the same cycle: LL bit ends 0 (flush wins). flush_i does not abort an in-progress bus cycle.
- Stores never write rdata_o except SC, which writes its status 0/1.

Test Plan:
- DATA_W=32, LB at addr 0x103, bus returns 0x11223380 after 3 wait states -> bus_sel_o=0001, resp_valid_o pulses 5 cycles after accept, rdata_o=0xFFFFFF80, exc_o=0. Repeat as LBU -> 0x00000080.
- SH at addr 0x202, wdata=0x0000BEEF -> bus_adr_o=0x200, bus_sel_o=0011, bus_dat_o=0xBEEFBEEF, bus_we_o=1.
- LW at addr 0x101 -> no bus_cyc_o, resp_valid_o in 2nd cycle, exc_o=1. In a separate run, LD with DATA_W=32 -> exc_o=1.
- LL at 0x40 (ack) then SC at 0x40 -> SC performs a bus write, rdata_o=1. A second SC -> no bus cycle, rdata_o=0. LL then flush_i then SC -> rdata_o=0.
- TIMEOUT=4, LW with no ack -> bus_cyc_o high for 4 cycles, then resp_valid_o with exc_o=3. ack and err asserted together -> exc_o=2.
- DATA_W=64, LWU at 0x1004, bus returns 0x0123456789ABCDEF -> bus_sel_o=0x0F, rdata_o=0x0000000089ABCDEF. Assert rst low during BUS -> bus_cyc_o=0 immediately, no resp_valid_o.

Source files
------------

// File: rtl/mem_bus_unit.sv
// Memory-access stage that runs loads, stores and LL/SC as multi-cycle Wishbone-style
// bus transactions, with stall generation, ack timeout, alignment checks and an LL bit.
module mem_bus_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  input  logic                op_store_i,
  input  logic [1:0]          op_size_i,
  input  logic                op_unsigned_i,
  input  logic                op_llsc_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                resp_valid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          exc_o,
  output logic                bus_cyc_o,
  output logic                bus_stb_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_adr_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [DATA_W-1:0]   bus_dat_o,
  input  logic [DATA_W-1:0]   bus_dat_i,
  input  logic                bus_ack_i,
  input  logic                bus_err_i
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam logic [OFFW:0] NB_L    = (OFFW+1)'(NB);
  localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                ll_q, ll_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [NB-1:0]       sel_q, sel_d;
  logic                we_q, we_d;
  logic                llsc_q, llsc_d;
  logic                uns_q, uns_d;
  logic [1:0]          size_q, size_d;
  logic [OFFW:0]       lsh_q, lsh_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          exc_q, exc_d;

  logic [OFFW:0]       req_bytes, req_lsh;
  logic [NB-1:0]       req_mask, req_sel;
  logic [DATA_W-1:0]   req_dat;
  logic                req_bad;

  logic [OFFW:0]       ld_bytes;
  logic [DATA_W-1:0]   ld_raw, ld_keep, ld_ext;
  logic                ld_msb;

  // Big-endian: the datum occupies lanes shifted up by (NB - offset - size) from lane 0.
  always_comb begin
    req_bytes = (OFFW+1)'(1) << op_size_i;
    req_lsh   = NB_L - {1'b0, addr_i[OFFW-1:0]} - req_bytes;
    req_mask  = ~({NB{1'b1}} << req_bytes);
    req_sel   = req_mask << req_lsh;
    req_bad   = ((({1'b0, addr_i[OFFW-1:0]}) & (req_bytes - 1'b1)) != '0)
             || ((op_size_i == 2'd3) && (DATA_W == 32))
             || (op_llsc_i && !op_size_i[1]);
    req_dat   = '0;
    for (int unsigned j = 0; j < NB; j++) begin
      case (op_size_i)
        2'd0:    req_dat[8*j +: 8] = wdata_i[7:0];
        2'd1:    req_dat[8*j +: 8] = wdata_i[8*(j%2) +: 8];
        2'd2:    req_dat[8*j +: 8] = wdata_i[8*(j%4) +: 8];
        default: req_dat[8*j +: 8] = wdata_i[8*j +: 8];
      endcase
    end
  end

  always_comb begin
    ld_bytes = (OFFW+1)'(1) << size_q;
    ld_raw   = bus_dat_i >> {lsh_q, 3'b000};
    ld_keep  = ~({DATA_W{1'b1}} << {ld_bytes, 3'b000});
    case (size_q)
      2'd0:    ld_msb = ld_raw[7];
      2'd1:    ld_msb = ld_raw[15];
      2'd2:    ld_msb = ld_raw[31];
      default: ld_msb = ld_raw[DATA_W-1];
    endcase
    ld_ext = (ld_raw & ld_keep) | ((ld_msb && !uns_q) ? ~ld_keep : '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ll_d    = ll_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    llsc_d  = llsc_q;
    uns_d   = uns_q;
    size_d  = size_q;
    lsh_d   = lsh_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          stall_o = 1'b1;
          if (req_bad) begin
            state_d = S_RESP;
            exc_d   = 2'd1;
          end else if (op_store_i && op_llsc_i && !ll_q) begin
            state_d = S_RESP;
            rdata_d = '0;
            exc_d   = 2'd0;
          end else begin
            state_d = S_BUS;
            cnt_d   = '0;
            adr_d   = {addr_i[ADDR_W-1:OFFW], {OFFW{1'b0}}};
            sel_d   = req_sel;
            we_d    = op_store_i;
            llsc_d  = op_llsc_i;
            uns_d   = op_unsigned_i;
            size_d  = op_size_i;
            lsh_d   = req_lsh;
            dat_d   = req_dat;
          end
        end
      end
      S_BUS: begin
        stall_o = 1'b1;
        if (bus_err_i) begin
          state_d = S_RESP;
          exc_d   = 2'd2;
          rdata_d = '0;
          cnt_d   = '0;
        end else if (bus_ack_i) begin
          state_d = S_RESP;
          exc_d   = 2'd0;
          cnt_d   = '0;
          if (!we_q) begin
            rdata_d = ld_ext;
            if (llsc_q) ll_d = 1'b1;
          end else if (llsc_q) begin
            rdata_d = {{(DATA_W-1){1'b0}}, 1'b1};
            ll_d    = 1'b0;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = S_RESP;
          exc_d   = 2'd3;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush overrides an LL completing in the same cycle.
    if (flush_i) ll_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ll_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      llsc_q  <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      lsh_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ll_q    <= ll_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      llsc_q  <= llsc_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      lsh_q   <= lsh_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

  assign resp_valid_o = (state_q == S_RESP);
  assign bus_cyc_o    = (state_q == S_BUS);
  assign bus_stb_o    = (state_q == S_BUS);
  assign bus_we_o     = we_q;
  assign bus_adr_o    = adr_q;
  assign bus_sel_o    = sel_q;
  assign bus_dat_o    = dat_q;
  assign rdata_o      = rdata_q;
  assign exc_o        = exc_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed bench for mem_bus_unit: a 32-bit instance (TIMEOUT=4) and a 64-bit instance.
module tb_mem_bus_unit;
  logic clk, rst;
  logic rv32, rv64, op_store, op_uns, op_llsc, flush, bus_ack, bus_err;
  logic [1:0]  op_size;
  logic [31:0] addr, wdata32, bus_dat32;
  logic [63:0] wdata64, bus_dat64;

  logic        stall32, rv32o, cyc32, stb32, we32;
  logic [31:0] rdata32, adr32, dq32;
  logic [1:0]  exc32;
  logic [3:0]  sel32;
  logic        stall64, rv64o, cyc64, stb64, we64;
  logic [63:0] rdata64, dq64;
  logic [31:0] adr64;
  logic [1:0]  exc64;
  logic [7:0]  sel64;

  int tests = 0;
  int fails = 0;

  mem_bus_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_d32 (
    .clk(clk), .rst(rst), .req_valid_i(rv32), .op_store_i(op_store), .op_size_i(op_size),
    .op_unsigned_i(op_uns), .op_llsc_i(op_llsc), .addr_i(addr), .wdata_i(wdata32),
    .flush_i(flush), .stall_o(stall32), .resp_valid_o(rv32o), .rdata_o(rdata32), .exc_o(exc32),
    .bus_cyc_o(cyc32), .bus_stb_o(stb32), .bus_we_o(we32), .bus_adr_o(adr32), .bus_sel_o(sel32),
    .bus_dat_o(dq32), .bus_dat_i(bus_dat32), .bus_ack_i(bus_ack), .bus_err_i(bus_err));

  mem_bus_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(255)) u_d64 (
    .clk(clk), .rst(rst), .req_valid_i(rv64), .op_store_i(op_store), .op_size_i(op_size),
    .op_unsigned_i(op_uns), .op_llsc_i(op_llsc), .addr_i(addr), .wdata_i(wdata64),
    .flush_i(flush), .stall_o(stall64), .resp_valid_o(rv64o), .rdata_o(rdata64), .exc_o(exc64),
    .bus_cyc_o(cyc64), .bus_stb_o(stb64), .bus_we_o(we64), .bus_adr_o(adr64), .bus_sel_o(sel64),
    .bus_dat_o(dq64), .bus_dat_i(bus_dat64), .bus_ack_i(bus_ack), .bus_err_i(bus_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input bit w, input bit st, input logic [1:0] sz, input bit uns,
                       input bit llsc, input logic [31:0] a, input logic [63:0] wd);
    @(posedge clk); #1;
    op_store = st; op_size = sz; op_uns = uns; op_llsc = llsc; addr = a;
    wdata32 = wd[31:0]; wdata64 = wd;
    if (w) rv64 = 1'b1; else rv32 = 1'b1;
    #1;
  endtask

  // Cycle n=1 is the cycle after acceptance; ack (and err if err_too) is driven in cycle ack_at.
  task automatic run(input bit w, input int ack_at, input bit err_too, input logic [63:0] rd,
                     input int flush_at, output int lat, output int ncyc, output logic [31:0] a,
                     output logic [7:0] s, output logic [63:0] d, output logic we, output logic stb);
    bit seen = 1'b0;
    lat = -1; ncyc = 0; a = '0; s = '0; d = '0; we = 1'b0; stb = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      bus_ack   = (n == ack_at);
      bus_err   = err_too && (n == ack_at);
      bus_dat32 = (n == ack_at) ? rd[31:0] : '0;
      bus_dat64 = (n == ack_at) ? rd : '0;
      flush     = (n == flush_at);
      if (w ? cyc64 : cyc32) begin
        ncyc++;
        if (!seen) begin
          seen = 1'b1;
          a   = w ? adr64 : adr32;
          s   = w ? sel64 : {4'b0, sel32};
          d   = w ? dq64 : {32'b0, dq32};
          we  = w ? we64 : we32;
          stb = w ? stb64 : stb32;
        end
      end
      if (w ? rv64o : rv32o) begin
        lat = n;
        break;
      end
    end
    rv32 = 1'b0; rv64 = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; flush = 1'b0;
  endtask

  int lat, ncyc;
  logic [31:0] ga;
  logic [7:0]  gs;
  logic [63:0] gd;
  logic        gwe, gstb;

  task automatic test_reset;
    #12;
    tests++; if (cyc32 !== 1'b0) begin fails++; $display("FAIL rst_cyc32: got %b want 0", cyc32); end
    tests++; if (rv32o !== 1'b0) begin fails++; $display("FAIL rst_resp32: got %b want 0", rv32o); end
    tests++; if (rdata32 !== 32'h0) begin fails++; $display("FAIL rst_rdata32: got %h want 0", rdata32); end
    tests++; if (exc32 !== 2'd0 || sel32 !== 4'h0) begin fails++; $display("FAIL rst_exc_sel32: got %0d/%h want 0/0", exc32, sel32); end
    tests++; if (cyc64 !== 1'b0 || stall64 !== 1'b0 || rdata64 !== 64'h0) begin fails++; $display("FAIL rst_d64: got cyc %b stall %b rdata %h want 0", cyc64, stall64, rdata64); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_load_byte;
    issue(0, 0, 2'd0, 0, 0, 32'h103, 64'h0);
    tests++; if (stall32 !== 1'b1) begin fails++; $display("FAIL lb_stall_accept: got %b want 1", stall32); end
    run(0, 4, 0, 64'h11223380, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (gs !== 8'h01 || ga !== 32'h100) begin fails++; $display("FAIL lb_sel_adr: got %h/%h want 01/00000100", gs, ga); end
    tests++; if (gwe !== 1'b0 || gstb !== 1'b1) begin fails++; $display("FAIL lb_we_stb: got %b/%b want 0/1", gwe, gstb); end
    tests++; if (lat !== 5 || ncyc !== 4) begin fails++; $display("FAIL lb_latency: got lat %0d bus %0d want 5 4", lat, ncyc); end
    tests++; if (rdata32 !== 32'hFFFFFF80 || exc32 !== 2'd0) begin fails++; $display("FAIL lb_rdata: got %h exc %0d want ffffff80 0", rdata32, exc32); end
    issue(0, 0, 2'd0, 1, 0, 32'h103, 64'h0);
    run(0, 4, 0, 64'h11223380, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (rdata32 !== 32'h00000080 || lat !== 5) begin fails++; $display("FAIL lbu_rdata: got %h lat %0d want 00000080 5", rdata32, lat); end
  endtask

  task automatic test_store_half;
    issue(0, 1, 2'd1, 0, 0, 32'h202, 64'h0000BEEF);
    run(0, 1, 0, 64'h0, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (ga !== 32'h200 || gs !== 8'h03) begin fails++; $display("FAIL sh_adr_sel: got %h/%h want 00000200/03", ga, gs); end
    tests++; if (gd !== 64'hBEEFBEEF || gwe !== 1'b1) begin fails++; $display("FAIL sh_dat_we: got %h/%b want beefbeef/1", gd, gwe); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL sh_latency: got %0d want 2", lat); end
    tests++; if (rdata32 !== 32'h00000080) begin fails++; $display("FAIL sh_rdata_kept: got %h want 00000080", rdata32); end
  endtask

  task automatic test_misaligned;
    issue(0, 0, 2'd3, 0, 0, 32'h100, 64'h0);
    run(0, 0, 0, 64'h0, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (exc32 !== 2'd1 || lat !== 1 || ncyc !== 0) begin fails++; $display("FAIL ld32_illegal: got exc %0d lat %0d bus %0d want 1 1 0", exc32, lat, ncyc); end
    issue(0, 0, 2'd2, 0, 0, 32'h104, 64'h0);
    run(0, 1, 0, 64'hCAFEBABE, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (rdata32 !== 32'hCAFEBABE || exc32 !== 2'd0 || gs !== 8'h0F) begin fails++; $display("FAIL lw_ok: got %h exc %0d sel %h want cafebabe 0 0f", rdata32, exc32, gs); end
    issue(0, 0, 2'd2, 0, 0, 32'h101, 64'h0);
    run(0, 0, 0, 64'h0, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (exc32 !== 2'd1 || lat !== 1 || ncyc !== 0) begin fails++; $display("FAIL lw_misaligned: got exc %0d lat %0d bus %0d want 1 1 0", exc32, lat, ncyc); end
    tests++; if (rdata32 !== 32'hCAFEBABE) begin fails++; $display("FAIL misaligned_rdata_kept: got %h want cafebabe", rdata32); end
  endtask

  task automatic test_llsc;
    issue(0, 0, 2'd2, 0, 1, 32'h40, 64'h0);
    run(0, 1, 0, 64'h12345678, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (rdata32 !== 32'h12345678 || exc32 !== 2'd0) begin fails++; $display("FAIL ll_rdata: got %h exc %0d want 12345678 0", rdata32, exc32); end
    issue(0, 1, 2'd2, 0, 1, 32'h40, 64'hA5A5A5A5);
    run(0, 1, 0, 64'h0, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (ncyc !== 1 || gwe !== 1'b1 || gd !== 64'hA5A5A5A5) begin fails++; $display("FAIL sc_bus: got bus %0d we %b dat %h want 1 1 a5a5a5a5", ncyc, gwe, gd); end
    tests++; if (rdata32 !== 32'h1 || lat !== 2) begin fails++; $display("FAIL sc_status: got %h lat %0d want 00000001 2", rdata32, lat); end
    issue(0, 1, 2'd2, 0, 1, 32'h40, 64'hA5A5A5A5);
    run(0, 0, 0, 64'h0, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (ncyc !== 0 || lat !== 1 || rdata32 !== 32'h0) begin fails++; $display("FAIL sc_second: got bus %0d lat %0d rdata %h want 0 1 0", ncyc, lat, rdata32); end
    issue(0, 0, 2'd2, 0, 1, 32'h40, 64'h0);
    run(0, 1, 0, 64'h12345678, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    issue(0, 1, 2'd2, 0, 1, 32'h40, 64'h1);
    run(0, 1, 0, 64'h0, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (ncyc !== 0 || rdata32 !== 32'h0) begin fails++; $display("FAIL sc_after_flush: got bus %0d rdata %h want 0 0", ncyc, rdata32); end
    issue(0, 0, 2'd2, 0, 1, 32'h40, 64'h0);
    run(0, 1, 0, 64'h12345678, 1, lat, ncyc, ga, gs, gd, gwe, gstb);
    issue(0, 1, 2'd2, 0, 1, 32'h40, 64'h1);
    run(0, 1, 0, 64'h0, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (ncyc !== 0 || rdata32 !== 32'h0) begin fails++; $display("FAIL sc_flush_with_ll_ack: got bus %0d rdata %h want 0 0", ncyc, rdata32); end
  endtask

  task automatic test_timeout;
    issue(0, 0, 2'd2, 0, 0, 32'h80, 64'h0);
    run(0, 0, 0, 64'h0, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (ncyc !== 4 || lat !== 5 || exc32 !== 2'd3) begin fails++; $display("FAIL timeout: got bus %0d lat %0d exc %0d want 4 5 3", ncyc, lat, exc32); end
  endtask

  task automatic test_bus_error;
    issue(0, 0, 2'd2, 0, 0, 32'h88, 64'h0);
    run(0, 1, 0, 64'h55AA55AA, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (rdata32 !== 32'h55AA55AA || exc32 !== 2'd0) begin fails++; $display("FAIL lw_before_err: got %h exc %0d want 55aa55aa 0", rdata32, exc32); end
    issue(0, 0, 2'd2, 0, 0, 32'h8C, 64'h0);
    run(0, 2, 1, 64'h77777777, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (exc32 !== 2'd2 || rdata32 !== 32'h0 || lat !== 3) begin fails++; $display("FAIL ack_err_together: got exc %0d rdata %h lat %0d want 2 0 3", exc32, rdata32, lat); end
  endtask

  task automatic test_wide;
    issue(1, 0, 2'd2, 1, 0, 32'h1004, 64'h0);
    run(1, 1, 0, 64'h0123456789ABCDEF, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (gs !== 8'h0F || ga !== 32'h1000 || gstb !== 1'b1) begin fails++; $display("FAIL lwu64_sel_adr: got %h/%h stb %b want 0f/00001000 1", gs, ga, gstb); end
    tests++; if (rdata64 !== 64'h0000000089ABCDEF || exc64 !== 2'd0 || lat !== 2) begin fails++; $display("FAIL lwu64_rdata: got %h exc %0d lat %0d want 0000000089abcdef 0 2", rdata64, exc64, lat); end
    issue(1, 0, 2'd1, 0, 0, 32'h1004, 64'h0);
    run(1, 1, 0, 64'h0123456789ABCDEF, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (rdata64 !== 64'hFFFFFFFFFFFF89AB || gs !== 8'h0C) begin fails++; $display("FAIL lh64: got %h sel %h want ffffffffffff89ab 0c", rdata64, gs); end
    issue(1, 0, 2'd3, 0, 0, 32'h1000, 64'h0);
    run(1, 1, 0, 64'h0123456789ABCDEF, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (rdata64 !== 64'h0123456789ABCDEF || exc64 !== 2'd0 || gs !== 8'hFF) begin fails++; $display("FAIL ld64: got %h exc %0d sel %h want 0123456789abcdef 0 ff", rdata64, exc64, gs); end
    issue(1, 1, 2'd0, 0, 0, 32'h1007, 64'h5A);
    run(1, 1, 0, 64'h0, 0, lat, ncyc, ga, gs, gd, gwe, gstb);
    tests++; if (gs !== 8'h01 || gd !== 64'h5A5A5A5A5A5A5A5A || gwe !== 1'b1) begin fails++; $display("FAIL sb64: got sel %h dat %h we %b want 01 5a5a5a5a5a5a5a5a 1", gs, gd, gwe); end
  endtask

  task automatic test_reset_mid;
    int seen_resp = 0;
    issue(1, 0, 2'd2, 0, 0, 32'h1008, 64'h0);
    @(posedge clk); #1;
    tests++; if (cyc64 !== 1'b1) begin fails++; $display("FAIL rstmid_in_bus: got %b want 1", cyc64); end
    rst = 1'b0; rv64 = 1'b0;
    #1;
    tests++; if (cyc64 !== 1'b0) begin fails++; $display("FAIL rstmid_cyc_drop: got %b want 0", cyc64); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 1) rst = 1'b1;
      if (rv64o) seen_resp++;
    end
    tests++; if (seen_resp !== 0 || cyc64 !== 1'b0) begin fails++; $display("FAIL rstmid_no_resp: got resp %0d cyc %b want 0 0", seen_resp, cyc64); end
  endtask

  initial begin
    rst = 1'b0; rv32 = 1'b0; rv64 = 1'b0; op_store = 1'b0; op_size = 2'd0; op_uns = 1'b0;
    op_llsc = 1'b0; addr = '0; wdata32 = '0; wdata64 = '0; flush = 1'b0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_dat32 = '0; bus_dat64 = '0;
    test_reset;
    test_load_byte;
    test_store_half;
    test_misaligned;
    test_llsc;
    test_timeout;
    test_bus_error;
    test_wide;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
